pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 76 +++++++
 tb/tb_pipe_stage_reg.sv | 108 ++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry valid/ready pipeline register with skid slot, flush, bubble masking and stall counter
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int NDATA = 2,
  parameter int CTRL_W = 3,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]        in_reg,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]        out_reg,
  output logic [CNT_W-1:0]        stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [NDATA*DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [REG_W-1:0] main_reg_q, main_reg_d, skid_reg_q, skid_reg_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic accept, take, load_in, load_skid, skid_to_main;
  always_comb begin
    in_ready = state_q != TWO;
    out_valid = state_q != EMPTY;
    accept = in_valid & in_ready;
    take = out_valid & out_ready;
    load_in = accept & ((state_q == EMPTY) | take);
    load_skid = accept & (state_q == ONE) & !take;
    skid_to_main = take & (state_q == TWO);
    state_d = flush ? EMPTY :
              (state_q == EMPTY) ? (accept ? ONE : EMPTY) :
              (state_q == ONE) ? ((accept & !take) ? TWO : (!accept & take) ? EMPTY : ONE) :
              (take ? ONE : TWO);
    main_ctrl_d = load_in ? in_ctrl : skid_to_main ? skid_ctrl_q : main_ctrl_q;
    main_data_d = load_in ? in_data : skid_to_main ? skid_data_q : main_data_q;
    main_reg_d = load_in ? in_reg : skid_to_main ? skid_reg_q : main_reg_q;
    skid_ctrl_d = load_skid ? in_ctrl : skid_ctrl_q;
    skid_data_d = load_skid ? in_data : skid_data_q;
    skid_reg_d = load_skid ? in_reg : skid_reg_q;
    stall_d = (in_valid & !in_ready & !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    out_ctrl = out_valid ? main_ctrl_q : '0;
    out_data = main_data_q;
    out_reg = main_reg_q;
    stall_cnt = stall_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_reg_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_reg_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_reg_q <= main_reg_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_reg_q <= skid_reg_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven and directed checks of pipe_stage_reg
module tb_pipe_stage_reg;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [2:0] in_ctrl = 0, out_ctrl;
  logic [15:0] in_data = 0, out_data;
  logic [4:0] in_reg = 0, out_reg;
  logic [1:0] stall_cnt;
  int checks = 0, errors = 0;
  pipe_stage_reg #(.DATA_W(8), .NDATA(2), .CTRL_W(3), .REG_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_reg(in_reg), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_reg(out_reg),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic iv; logic [2:0] ic; logic [15:0] id; logic [4:0] ir; logic fl; logic ordy;
    logic ev; logic erdy; logic [2:0] ec; logic [15:0] ed; logic [4:0] er;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(input logic iv, input logic [2:0] ic, input logic [15:0] id,
                              input logic [4:0] ir, input logic fl, input logic ordy,
                              input logic ev, input logic erdy, input logic [2:0] ec,
                              input logic [15:0] ed, input logic [4:0] er);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ir = ir; v.fl = fl; v.ordy = ordy;
    v.ev = ev; v.erdy = erdy; v.ec = ec; v.ed = ed; v.er = er;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic iv, input logic [2:0] ic, input logic [15:0] id,
                       input logic [4:0] ir, input logic fl, input logic ordy);
    in_valid = iv; in_ctrl = ic; in_data = id; in_reg = ir; flush = fl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] c;
    for (int i = 0; i < 8; i++) begin
      c = (i == 7) ? 3'b101 : 3'(i + 1);
      vt.push_back(mk(1, c, 16'h0010 + 16'(i), 5'(i), 0, 1, 1, 1, c, 16'h0010 + 16'(i), 5'(i)));
    end
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 3'b001, 16'h00A1, 5'd1, 0, 0, 1, 1, 3'b001, 16'h00A1, 5'd1));
    vt.push_back(mk(1, 3'b010, 16'h00B2, 5'd2, 0, 0, 1, 0, 3'b001, 16'h00A1, 5'd1));
    vt.push_back(mk(1, 3'b100, 16'h00DD, 5'd4, 0, 0, 1, 0, 3'b001, 16'h00A1, 5'd1));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3'b010, 16'h00B2, 5'd2));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 3'b001, 16'h00A1, 5'd1, 0, 0, 1, 1, 3'b001, 16'h00A1, 5'd1));
    vt.push_back(mk(1, 3'b010, 16'h00B2, 5'd2, 0, 0, 1, 0, 3'b001, 16'h00A1, 5'd1));
    vt.push_back(mk(1, 3'b111, 16'h00C3, 5'd3, 1, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 3'b110, 16'h00E5, 5'd6, 0, 1, 1, 1, 3'b110, 16'h00E5, 5'd6));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_ctrl", 32'(out_ctrl), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_reg", 32'(out_reg), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    @(posedge clk);
    #1 rst = 0;
    foreach (vt[k]) begin
      drive(vt[k].iv, vt[k].ic, vt[k].id, vt[k].ir, vt[k].fl, vt[k].ordy);
      chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vt[k].ev));
      chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vt[k].erdy));
      chk($sformatf("vec%0d_out_ctrl", k), 32'(out_ctrl), 32'(vt[k].ec));
      if (vt[k].ev) begin
        chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(vt[k].ed));
        chk($sformatf("vec%0d_out_reg", k), 32'(out_reg), 32'(vt[k].er));
      end
    end
    drive(1, 3'b011, 16'h00A1, 5'd1, 0, 0);
    drive(1, 3'b011, 16'h00B2, 5'd2, 0, 0);
    chk("two_in_ready", 32'(in_ready), 0);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_ctrl", 32'(out_ctrl), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_out_reg", 32'(out_reg), 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    #1 rst = 0;
    drive(0, 0, 0, 0, 0, 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    drive(1, 3'b001, 16'h0001, 5'd1, 0, 0);
    drive(1, 3'b001, 16'h0002, 5'd2, 0, 0);
    chk("stall_start", 32'(stall_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'b001, 16'h0003, 5'd3, 0, 0);
      chk($sformatf("stall_%0d", i), 32'(stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("stall_hold_data", 32'(out_data), 32'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
